echo_delay_ram_scheduler: RTL

- Sequences all accesses to the single-port delay RAM behind the echo effect.
- For each incoming stereo sample it reads that channel's sample from delay_samples frames earlier, then overwrites the slot with the new sample.
- It emits the current/delayed pair to the echo mixer.
- Sits in the clk domain between the dual-clock sync buffer and the mixing/feedback arithmetic.

---
 rtl/echo_delay_ram_scheduler.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/echo_delay_ram_scheduler.sv
// Echo delay RAM scheduler: per-sample read-then-overwrite of a single-port delay RAM.
// Optional power-up RAM sweep when DELAY_RAM_CLEAR_EN is defined.
module echo_delay_ram_scheduler #(
    parameter int audio_width   = 16,
    parameter int delay_samples = 2048,
    localparam int addr_width   = $clog2(delay_samples) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic                   i_is_left,
    input  logic [audio_width-1:0] i_audio,
    output logic [addr_width-1:0]  ram_addr,
    output logic                   ram_we,
    output logic [audio_width-1:0] ram_wdata,
    input  logic [audio_width-1:0] ram_rdata,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic                   o_is_left,
    output logic [audio_width-1:0] o_audio,
    output logic [audio_width-1:0] o_delayed
);

    localparam int ptr_width = addr_width - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_OUTPUT,
        S_CLEAR
    } state_t;

`ifdef DELAY_RAM_CLEAR_EN
    localparam state_t RST_STATE = S_CLEAR;
    localparam logic   RST_READY = 1'b0;
`else
    localparam state_t RST_STATE = S_IDLE;
    localparam logic   RST_READY = 1'b1;
`endif

    state_t                 r_state;
    logic [ptr_width-1:0]   r_ptr;
    logic                   r_primed;
    logic                   r_i_ready;
    logic                   r_o_valid;
    logic                   r_ram_we;
    logic [addr_width-1:0]  r_ram_addr;
    logic [audio_width-1:0] r_ram_wdata;
    logic                   r_o_is_left;
    logic [audio_width-1:0] r_o_audio;
    logic [audio_width-1:0] r_o_delayed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= RST_STATE;
            r_ptr       <= '0;
            r_primed    <= 1'b0;
            r_i_ready   <= RST_READY;
            r_o_valid   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_o_is_left <= 1'b0;
            r_o_audio   <= '0;
            r_o_delayed <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_i_ready   <= 1'b0;
                        r_o_is_left <= i_is_left;
                        r_o_audio   <= i_audio;
                        r_ram_addr  <= {~i_is_left, r_ptr};
                        r_state     <= S_READ;
                    end
                end
                S_READ: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    // Until the pointer has wrapped once, the slot was never written.
                    r_o_delayed <= r_primed ? ram_rdata : '0;
                    r_ram_we    <= 1'b1;
                    r_ram_wdata <= r_o_audio;
                    r_state     <= S_WRITE;
                end
                S_WRITE: begin
                    r_ram_we  <= 1'b0;
                    r_o_valid <= 1'b1;
                    if (!r_o_is_left) begin
                        r_ptr <= r_ptr + 1'b1;
                        if (r_ptr == '1)
                            r_primed <= 1'b1;
                    end
                    r_state <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (o_ready) begin
                        r_o_valid <= 1'b0;
                        r_i_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
`ifdef DELAY_RAM_CLEAR_EN
                S_CLEAR: begin
                    // Zero-fill both channels, one address per clock, ascending.
                    if (!r_ram_we) begin
                        r_ram_we <= 1'b1;
                    end else if (r_ram_addr == '1) begin
                        r_ram_we   <= 1'b0;
                        r_ram_addr <= '0;
                        r_primed   <= 1'b1;
                        r_i_ready  <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_ram_addr <= r_ram_addr + 1'b1;
                    end
                end
`endif
                default: begin
                    r_ram_we  <= 1'b0;
                    r_o_valid <= 1'b0;
                    r_i_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign i_ready   = r_i_ready;
    assign o_valid   = r_o_valid;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign o_is_left = r_o_is_left;
    assign o_audio   = r_o_audio;
    assign o_delayed = r_o_delayed;

endmodule
